// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch (IF) and load/store (MEM).
// Each access runs for a fixed MEM_LATENCY cycles and then returns a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  input  logic                 i_abort,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  output logic                 i_stall,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 d_stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [15:0]          num_i_access,
  output logic [15:0]          num_d_access
);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 discard_q, discard_d;
  logic                 i_ready_q, i_ready_d;
  logic                 d_ready_q, d_ready_d;
  logic                 mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic [15:0]          num_i_q, num_i_d;
  logic [15:0]          num_d_q, num_d_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    discard_d   = discard_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    num_i_d     = num_i_q;
    num_d_d     = num_d_q;

    case (state_q)
      IDLE: begin
        // A port still showing its ready pulse is skipped so its request is not served twice.
        if (d_req && !d_ready_q) begin
          state_d     = D_ACC;
          cnt_d       = LAT_LOAD;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_we_d    = d_we;
        end else if (i_req && !i_ready_q) begin
          state_d    = I_ACC;
          cnt_d      = LAT_LOAD;
          mem_addr_d = i_addr;
          mem_we_d   = 1'b0;
        end
      end
      I_ACC: begin
        if (i_abort) discard_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d   = IDLE;
          discard_d = 1'b0;
          // A flushed fetch still occupies the memory but its result is dropped silently.
          if (!(discard_q || i_abort)) begin
            i_rdata_d = mem_rdata;
            i_ready_d = 1'b1;
            num_i_d   = num_i_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      D_ACC: begin
        if (cnt_q == 4'd0) begin
          state_d   = IDLE;
          d_ready_d = 1'b1;
          num_d_d   = num_d_q + 16'd1;
          mem_we_d  = 1'b0;
          if (!mem_we_q) d_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      num_i_q     <= '0;
      num_d_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      discard_q   <= discard_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      num_i_q     <= num_i_d;
      num_d_q     <= num_d_d;
    end
  end

  assign mem_req      = (state_q != IDLE);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign i_ready      = i_ready_q;
  assign d_ready      = d_ready_q;
  assign num_i_access = num_i_q;
  assign num_d_access = num_d_q;
  assign i_stall      = i_req & ~i_ready_q;
  assign d_stall      = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a MEM_LATENCY=2 instance for directed traffic
// and a MEM_LATENCY=1 instance for continuous fetch streaming.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic        a_i_req, a_i_abort, a_d_req, a_d_we;
  logic [15:0] a_i_addr, a_d_addr, a_d_wdata;
  logic [15:0] a_i_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata, a_num_i, a_num_d;
  logic        a_i_ready, a_i_stall, a_d_ready, a_d_stall, a_mem_req, a_mem_we;

  logic        b_i_req, b_i_abort, b_d_req, b_d_we;
  logic [15:0] b_i_addr, b_d_addr, b_d_wdata;
  logic [15:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata, b_num_i, b_num_d;
  logic        b_i_ready, b_i_stall, b_d_ready, b_d_stall, b_mem_req, b_mem_we;

  function automatic logic [15:0] mem_model(input logic [15:0] a);
    case (a)
      16'h0010: return 16'h6A01;
      16'h0200: return 16'h1234;
      default:  return a ^ 16'hA5C3;
    endcase
  endfunction

  assign a_mem_rdata = mem_model(a_mem_addr);
  assign b_mem_rdata = mem_model(b_mem_addr);

  mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(2)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_abort(a_i_abort),
    .i_rdata(a_i_rdata), .i_ready(a_i_ready), .i_stall(a_i_stall),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_ready(a_d_ready), .d_stall(a_d_stall),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .num_i_access(a_num_i), .num_d_access(a_num_d)
  );

  mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(1)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_abort(b_i_abort),
    .i_rdata(b_i_rdata), .i_ready(b_i_ready), .i_stall(b_i_stall),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_ready(b_d_ready), .d_stall(b_d_stall),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .num_i_access(b_num_i), .num_d_access(b_num_d)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] rdata;
    logic [15:0] count;
  } exp_t;

  exp_t exp_i[$];
  exp_t exp_d[$];

  // Monitor for the latency-2 instance: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (a_i_ready === 1'b1) begin
      if (exp_i.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected i_ready: got 1 expected 0 (i_rdata %h)", a_i_rdata);
      end else begin
        exp_t e;
        e = exp_i.pop_front();
        check("i_rdata", a_i_rdata, e.rdata);
        check("num_i_access", a_num_i, e.count);
      end
    end
    if (a_d_ready === 1'b1) begin
      if (exp_d.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected d_ready: got 1 expected 0 (d_rdata %h)", a_d_rdata);
      end else begin
        exp_t e;
        e = exp_d.pop_front();
        check("d_rdata", a_d_rdata, e.rdata);
        check("num_d_access", a_num_d, e.count);
      end
    end
  end

  int  b_pulses = 0;
  logic b_prev_ready = 1'b0;
  always @(negedge clk) begin
    if (b_i_ready === 1'b1) begin
      b_pulses++;
      check("lat1 i_ready back-to-back", b_prev_ready, 1'b0);
      check("lat1 i_rdata", b_i_rdata, mem_model(16'h0060));
    end
    b_prev_ready = b_i_ready;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One latency-2 access on dut_a; cycle 0 is the request cycle.
  task automatic run_access(input bit is_d, input bit we, input logic [15:0] addr,
                            input logic [15:0] wdata, input string tag);
    cyc();
    if (is_d) begin
      a_d_req = 1'b1; a_d_we = we; a_d_addr = addr; a_d_wdata = wdata;
    end else begin
      a_i_req = 1'b1; a_i_addr = addr;
    end
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) cyc();
      if (c == 4) begin
        a_d_req = 1'b0; a_i_req = 1'b0; a_d_we = 1'b0;
      end
      #3;
      check({tag, " mem_req"}, a_mem_req, (c == 1 || c == 2));
      check({tag, " mem_we"}, a_mem_we, (we && (c == 1 || c == 2)));
      if (c == 1 || c == 2) begin
        check({tag, " mem_addr"}, a_mem_addr, addr);
        if (we) check({tag, " mem_wdata"}, a_mem_wdata, wdata);
      end
      check({tag, " stall"}, is_d ? a_d_stall : a_i_stall, (c <= 2));
    end
  endtask

  initial begin : watchdog
    #60000;
    errors++;
    $display("FAIL timeout: got no completion expected $finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : stim
    logic [15:0] prev_i;
    a_i_req = 0; a_i_abort = 0; a_d_req = 0; a_d_we = 0;
    a_i_addr = 0; a_d_addr = 0; a_d_wdata = 0;
    b_i_req = 0; b_i_abort = 0; b_d_req = 0; b_d_we = 0;
    b_i_addr = 0; b_d_addr = 0; b_d_wdata = 0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    check("reset mem_req", a_mem_req, 0);
    check("reset mem_addr", a_mem_addr, 0);
    check("reset i_ready", a_i_ready, 0);
    check("reset num_i", a_num_i, 0);
    @(posedge clk); @(posedge clk); #3 reset_n = 1'b1;

    // Single fetch
    exp_i.push_back('{16'h6A01, 16'd1});
    run_access(1'b0, 1'b0, 16'h0010, 16'h0000, "fetch");

    // Simultaneous load and fetch: data first, fetch granted in the d_ready cycle
    exp_d.push_back('{16'h1234, 16'd1});
    exp_i.push_back('{mem_model(16'h0020), 16'd2});
    cyc();
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 16'h0200;
    a_i_req = 1'b1; a_i_addr = 16'h0020;
    for (int c = 0; c <= 7; c++) begin
      if (c > 0) cyc();
      if (c == 4) a_d_req = 1'b0;
      if (c == 7) a_i_req = 1'b0;
      #3;
      check("both mem_req", a_mem_req, (c == 1 || c == 2 || c == 4 || c == 5));
      if (c == 1 || c == 2) check("both mem_addr d", a_mem_addr, 16'h0200);
      if (c == 4 || c == 5) check("both mem_addr i", a_mem_addr, 16'h0020);
      check("both i_stall", a_i_stall, (c <= 5));
      check("both d_stall", a_d_stall, (c <= 2));
    end

    // Store leaves d_rdata at the last load value
    exp_d.push_back('{16'h1234, 16'd2});
    run_access(1'b1, 1'b1, 16'h0300, 16'hBEEF, "store");

    // Aborted fetch: memory still busy for two cycles, no ready
    prev_i = mem_model(16'h0020);
    cyc();
    a_i_req = 1'b1; a_i_addr = 16'h0040;
    for (int c = 0; c <= 4; c++) begin
      if (c > 0) cyc();
      if (c == 1) a_i_abort = 1'b1;
      if (c == 2) begin a_i_abort = 1'b0; a_i_req = 1'b0; end
      #3;
      check("abort mem_req", a_mem_req, (c == 1 || c == 2));
      if (c == 3) check("abort i_ready", a_i_ready, 0);
    end
    check("abort i_rdata kept", a_i_rdata, prev_i);
    check("abort num_i kept", a_num_i, 16'd2);
    exp_i.push_back('{mem_model(16'h0050), 16'd3});
    run_access(1'b0, 1'b0, 16'h0050, 16'h0000, "post-abort fetch");

    // Reset during D_ACC
    cyc();
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 16'h0400;
    cyc();
    check("pre-reset mem_req", a_mem_req, 1);
    reset_n = 1'b0;
    #1;
    check("mid reset mem_req", a_mem_req, 0);
    check("mid reset mem_addr", a_mem_addr, 0);
    check("mid reset i_rdata", a_i_rdata, 0);
    check("mid reset d_rdata", a_d_rdata, 0);
    check("mid reset num_i", a_num_i, 0);
    check("mid reset num_d", a_num_d, 0);
    check("mid reset d_ready", a_d_ready, 0);
    a_d_req = 1'b0;
    #1 reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      #3;
      check("post reset mem_req", a_mem_req, 0);
      check("post reset d_ready", a_d_ready, 0);
    end

    // Counter wrap
    cyc();
    force dut_a.num_d_q = 16'hFFFF;
    #1 release dut_a.num_d_q;
    #1 check("preset num_d", a_num_d, 16'hFFFF);
    exp_d.push_back('{mem_model(16'h0500), 16'h0000});
    run_access(1'b1, 1'b0, 16'h0500, 16'h0000, "wrap load");

    // MEM_LATENCY=1 streaming fetches
    cyc();
    b_i_req = 1'b1; b_i_addr = 16'h0060;
    repeat (30) cyc();
    b_i_req = 1'b0;
    repeat (5) cyc();
    check("lat1 fetch throughput", (b_pulses >= 8), 1);
    check("lat1 num_i_access", b_num_i, b_pulses[15:0]);

    repeat (3) cyc();
    check("pending i expectations", exp_i.size(), 0);
    check("pending d expectations", exp_d.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
